// File: rtl/linear_tile_feeder.sv
// Tile sequencer for the 16-lane linear layer: streams x and weight rows from RAM,
// holds the per-tile bias row, then writes each finished result row to the output RAM.
module linear_tile_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_W     = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [15:0]                len,
  input  logic [7:0]                 num_tiles,
  input  logic [ADDR_W-1:0]          x_base,
  input  logic [ADDR_W-1:0]          w_base,
  input  logic [ADDR_W-1:0]          b_base,
  input  logic [ADDR_W-1:0]          y_base,
  output logic                       busy,
  output logic                       done,
  input  logic                       mem_gnt,
  output logic                       mem_rd_en,
  output logic [ADDR_W-1:0]          x_addr,
  output logic [ADDR_W-1:0]          w_addr,
  input  logic [DATA_WIDTH-1:0]      x_rdata,
  input  logic [16*DATA_WIDTH-1:0]   w_rdata,
  output logic                       b_rd_en,
  output logic [ADDR_W-1:0]          b_addr,
  input  logic [16*DATA_WIDTH-1:0]   b_rdata,
  output logic                       y_we,
  output logic [ADDR_W-1:0]          y_addr,
  output logic [16*DATA_WIDTH-1:0]   y_wdata,
  output logic                       lin_start,
  output logic                       lin_en,
  output logic [15:0]                lin_len,
  output logic [DATA_WIDTH-1:0]      lin_x_val,
  output logic [16*DATA_WIDTH-1:0]   lin_W_row_vals,
  output logic [16*DATA_WIDTH-1:0]   lin_bias_vals,
  input  logic                       lin_done,
  input  logic [16*DATA_WIDTH-1:0]   lin_y_out
);

  localparam int ROW_W = 16 * DATA_WIDTH;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD_BIAS = 3'd1,
    KICK      = 3'd2,
    STREAM    = 3'd3,
    WAIT_DONE = 3'd4,
    WRITE     = 3'd5,
    FINISH    = 3'd6
  } state_t;

  state_t              state_r;
  state_t              next_state_s;
  logic [15:0]         len_r;
  logic [7:0]          tiles_r;
  logic [7:0]          tile_r;
  logic [15:0]         k_r;
  logic [ADDR_W-1:0]   x_base_r;
  logic [ADDR_W-1:0]   b_base_r;
  logic [ADDR_W-1:0]   y_base_r;
  logic [ADDR_W-1:0]   w_ptr_r;
  logic                lin_en_r;
  logic [ROW_W-1:0]    bias_r;
  logic [ROW_W-1:0]    y_row_r;
  logic                issue_s;
  logic                bias_rd_s;
  logic                last_issue_s;
  logic                last_tile_s;

  // Reads only go out while the shared port is granted; a denied cycle simply holds k/w_ptr.
  assign issue_s      = (state_r == STREAM) && mem_gnt;
  assign bias_rd_s    = (state_r == LOAD_BIAS) && mem_gnt;
  assign last_issue_s = issue_s && (k_r == (len_r - 16'd1));
  assign last_tile_s  = (({1'b0, tile_r} + 9'd1) == {1'b0, tiles_r});

  // Next-state decode of the tile sequencer.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if ((len == 16'd0) || (num_tiles == 8'd0)) begin
            next_state_s = FINISH;
          end else begin
            next_state_s = LOAD_BIAS;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      LOAD_BIAS: begin
        if (mem_gnt) begin
          next_state_s = KICK;
        end else begin
          next_state_s = LOAD_BIAS;
        end
      end
      KICK:      next_state_s = STREAM;
      STREAM: begin
        if (last_issue_s) begin
          next_state_s = WAIT_DONE;
        end else begin
          next_state_s = STREAM;
        end
      end
      WAIT_DONE: begin
        if (lin_done) begin
          next_state_s = WRITE;
        end else begin
          next_state_s = WAIT_DONE;
        end
      end
      WRITE: begin
        if (last_tile_s) begin
          next_state_s = FINISH;
        end else begin
          next_state_s = LOAD_BIAS;
        end
      end
      FINISH:    next_state_s = IDLE;
      default:   next_state_s = IDLE;
    endcase
  end

  // State register plus command, pointer and row holding registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      len_r    <= 16'd0;
      tiles_r  <= 8'd0;
      tile_r   <= 8'd0;
      k_r      <= 16'd0;
      x_base_r <= {ADDR_W{1'b0}};
      b_base_r <= {ADDR_W{1'b0}};
      y_base_r <= {ADDR_W{1'b0}};
      w_ptr_r  <= {ADDR_W{1'b0}};
      lin_en_r <= 1'b0;
      bias_r   <= {ROW_W{1'b0}};
      y_row_r  <= {ROW_W{1'b0}};
    end else begin
      state_r  <= next_state_s;
      lin_en_r <= issue_s;
      case (state_r)
        IDLE: begin
          if (start) begin
            len_r    <= len;
            tiles_r  <= num_tiles;
            x_base_r <= x_base;
            b_base_r <= b_base;
            y_base_r <= y_base;
            w_ptr_r  <= w_base;
            tile_r   <= 8'd0;
            k_r      <= 16'd0;
          end
        end
        KICK: begin
          bias_r <= b_rdata;
          k_r    <= 16'd0;
        end
        STREAM: begin
          // w_ptr is never rewound, so tile t's rows follow tile t-1's rows in weight RAM.
          if (issue_s) begin
            k_r     <= k_r + 16'd1;
            w_ptr_r <= w_ptr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          end
        end
        WAIT_DONE: begin
          if (lin_done) begin
            y_row_r <= lin_y_out;
          end
        end
        WRITE:   tile_r <= tile_r + 8'd1;
        default: tile_r <= tile_r;
      endcase
    end
  end

  assign busy      = (state_r != IDLE);
  assign done      = (state_r == FINISH);
  assign mem_rd_en = issue_s;
  assign x_addr    = issue_s ? (x_base_r + ADDR_W'(k_r)) : {ADDR_W{1'b0}};
  assign w_addr    = issue_s ? w_ptr_r : {ADDR_W{1'b0}};
  assign b_rd_en   = bias_rd_s;
  assign b_addr    = bias_rd_s ? (b_base_r + ADDR_W'(tile_r)) : {ADDR_W{1'b0}};
  assign y_we      = (state_r == WRITE);
  assign y_addr    = (state_r == WRITE) ? (y_base_r + ADDR_W'(tile_r)) : {ADDR_W{1'b0}};
  assign y_wdata   = y_row_r;
  assign lin_start = (state_r == KICK);
  assign lin_en    = lin_en_r;
  assign lin_len   = len_r;

  // RAM data is only presented to the layer in cycles it is actually valid.
  assign lin_x_val      = lin_en_r ? x_rdata : {DATA_WIDTH{1'b0}};
  assign lin_W_row_vals = lin_en_r ? w_rdata : {ROW_W{1'b0}};
  assign lin_bias_vals  = bias_r;

endmodule
